usb_tx_encoder: RTL and testbench
=================================

# usb_tx_encoder

Downstream consumer of the TX data buffer in the USB full-speed endpoint. On a packet request from the protocol controller it serialises SYNC, PID, optional payload pulled byte-by-byte from the buffer, and CRC16. It applies bit stuffing and NRZI encoding, then drives the D+/D− lines and finishes with EOP.

## Interface
- CLKS_PER_BIT, 8, system clocks per USB bit time (96 MHz clk → 12 Mb/s)
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  asynchronous, active-low reset
- tx_packet  in  3  request code sampled in IDLE: 0 none, 1 DATA0, 2 ACK, 3 NAK, 4 STALL, 5–7 invalid
- buffer_occupancy  in  7  bytes waiting in the TX buffer (0–64)
- tx_packet_data  in  8  head byte of the TX buffer
- get_tx_packet_data  out  1  one-cycle pop strobe to the buffer
- dplus_out  out  1  D+ line
- dminus_out  out  1  D− line
- tx_transfer_active  out  1  high while a packet is on the line
- tx_error  out  1  one-cycle pulse on an invalid request

## Operation
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J.
- Transitions:
  - IDLE→SYNC on codes 1–4.
  - SYNC→PID after 8 bits.
  - PID→DATA if DATA0 and occupancy>0; PID→CRC_LO if DATA0 and occupancy=0; PID→EOP_SE0 for ACK/NAK/STALL.
  - DATA repeats while occupancy>0 at a byte boundary, else →CRC_LO.
  - CRC_LO→CRC_HI→EOP_SE0.
  - EOP_SE0 (2 bit times)→EOP_J (1 bit time)→IDLE.
- Codes 5–7 in IDLE: tx_error pulses for 1 cycle; no transmission; state stays IDLE.
- Bytes go out LSB first.
  - SYNC = 0x80.
  - PIDs: DATA0 0xC3, ACK 0xD2, NAK 0x5A, STALL 0x1E.
- CRC16:
  - Polynomial 0x8005, initialised to 0xFFFF at PID→DATA/CRC_LO.
  - Updated per payload data bit; stuffed bits are excluded.
  - Transmitted as the one's complement, low byte first, each byte LSB first.
- Payload fetch:
  - get_tx_packet_data asserts for exactly one cycle, on the final clock of the last bit of the preceding byte (PID or data), whenever the next state is DATA.
  - tx_packet_data is captured on that same edge; the buffer pops on that edge.
  - No other pops occur; a 0-length DATA0 issues no pops.
- Bit stuffing:
  - The ones-run counter resets entering SYNC.
  - After six consecutive 1s (pre-NRZI), one 0 bit is inserted and the counter clears.
  - Stuffing applies through SYNC, PID, DATA and CRC; it never applies in EOP.
  - Stuffing takes one full bit time and stalls the byte shifter and the pop strobe.
- NRZI:
  - A 0 toggles the line between J (D+=1, D−=0) and K (D+=0, D−=1); a 1 holds it.
  - The line is J entering SYNC.
- EOP: SE0 (both 0) for 2 bit times, then J for 1 bit time.

## Timing
- Reset values:
  - dplus_out=1, dminus_out=0.
  - tx_transfer_active=0, get_tx_packet_data=0, tx_error=0.
  - State IDLE; NRZI level J; CRC 0xFFFF.
- Request latency: tx_packet is sampled at edge N in IDLE; the first SYNC bit is on the lines from edge N+1.
  - tx_transfer_active rises at edge N+1.
  - It falls at the edge ending the EOP J bit.
- Every bit, including stuffed bits, is held exactly CLKS_PER_BIT cycles.
- tx_packet is ignored outside IDLE. A request can be accepted on the edge that returns the encoder to IDLE+1; there is no back-to-back accept on the exit edge.
- Reset mid-packet: all outputs return to reset values immediately (asynchronous). No EOP is sent. There are no pops after the reset assertion.

## Test plan
- Reset: assert n_rst=0 mid-DATA → dplus=1, dminus=0, active=0, get=0 immediately; after release the encoder idles with the line at J.
- ACK: tx_packet=2 → 19 bit times (152 cycles) with active high.
  - Lines after J-start: SYNC KJKJKJKK.
  - Then ACK PID with no stuffing.
  - Then SE0, SE0, J.
  - get_tx_packet_data never asserts.
- Zero-length DATA0: occupancy=0, tx_packet=1 → PID 0xC3, CRC field 0x0000 (16 zero bits), no pops, 35 bit times (280 cycles).
- Stuffing: DATA0 with 1 byte 0xFF → exactly one pop, at the last clock of the PID. A stuffed 0 is inserted after the 4th payload bit (6th consecutive 1).
  - The transmitted CRC matches the reference model over 0xFF.
  - Frame length is 8+8+9+16+3 bit times plus any CRC stuff bits.
- Full payload: 64 bytes 0x00..0x3F → 64 single-cycle pops spaced 8 bit times apart (plus stuffing stalls), bytes serialised LSB first, CRC matches the model.
- Invalid: tx_packet=6 in IDLE → tx_error high for exactly 1 cycle, line stays J, active stays 0.

Source files
------------

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, PID, optional payload and CRC16 with
// bit stuffing and NRZI onto D+/D-, closed by an SE0-SE0-J end of packet.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_transfer_active,
  output logic       tx_error
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0] PID_DATA0 = 8'hC3;

  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J} state_t;

  state_t        state, state_nxt;
  logic          start_q, start_nxt;
  logic [7:0]    pid_q, pid_nxt;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          stuff_active, stuff_nxt;
  logic [2:0]    ones_cnt, ones_nxt;
  logic          prev_lvl, lvl_nxt;
  logic [15:0]   crc, crc_nxt, crc_step;
  logic          err_q, err_nxt;
  logic          tx_bit, line_lvl, stuffable, bit_end, need_stuff, advance;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      pid_q        <= 8'h00;
      clk_cnt      <= '0;
      bit_idx      <= 3'd0;
      shift        <= 8'h00;
      stuff_active <= 1'b0;
      ones_cnt     <= 3'd0;
      prev_lvl     <= 1'b1;
      crc          <= 16'hFFFF;
      err_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      start_q      <= start_nxt;
      pid_q        <= pid_nxt;
      clk_cnt      <= clk_cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      shift        <= shift_nxt;
      stuff_active <= stuff_nxt;
      ones_cnt     <= ones_nxt;
      prev_lvl     <= lvl_nxt;
      crc          <= crc_nxt;
      err_q        <= err_nxt;
    end
  end

  // prev_lvl holds the level of the previous bit; the current bit's level follows from it.
  always_comb begin
    tx_bit     = stuff_active ? 1'b0 : shift[0];
    line_lvl   = tx_bit ? prev_lvl : ~prev_lvl;
    stuffable  = state inside {SYNC, PID, DATA, CRC_LO, CRC_HI};
    bit_end    = (clk_cnt == '0);
    need_stuff = stuffable && !stuff_active && shift[0] && (ones_cnt == 3'd5);
    advance    = bit_end && !need_stuff;
    crc_step   = {crc[14:0], 1'b0} ^ ((shift[0] ^ crc[15]) ? 16'h8005 : 16'h0000);
  end

  always_comb begin
    state_nxt          = state;
    start_nxt          = start_q;
    pid_nxt            = pid_q;
    clk_cnt_nxt        = clk_cnt;
    bit_idx_nxt        = bit_idx;
    shift_nxt          = shift;
    stuff_nxt          = stuff_active;
    ones_nxt           = ones_cnt;
    lvl_nxt            = prev_lvl;
    crc_nxt            = crc;
    err_nxt            = 1'b0;
    get_tx_packet_data = 1'b0;

    if (state != IDLE)
      clk_cnt_nxt = bit_end ? CNT_LOAD : clk_cnt - 1'b1;

    if (bit_end && stuffable) begin
      lvl_nxt = line_lvl;
      if (stuff_active) begin
        stuff_nxt = 1'b0;
        ones_nxt  = 3'd0;
      end else begin
        ones_nxt = shift[0] ? ones_cnt + 3'd1 : 3'd0;
        if (need_stuff) begin
          stuff_nxt = 1'b1;
          ones_nxt  = 3'd0;
        end
        if (state == DATA)
          crc_nxt = crc_step;
      end
    end

    case (state)
      IDLE: begin
        if (start_q) begin
          state_nxt   = SYNC;
          start_nxt   = 1'b0;
          clk_cnt_nxt = CNT_LOAD;
          bit_idx_nxt = 3'd0;
          shift_nxt   = 8'h80;
          stuff_nxt   = 1'b0;
          ones_nxt    = 3'd0;
          lvl_nxt     = 1'b1;
        end else if (tx_packet inside {[3'd1:3'd4]}) begin
          start_nxt = 1'b1;
          case (tx_packet)
            3'd1:    pid_nxt = PID_DATA0;
            3'd2:    pid_nxt = 8'hD2;
            3'd3:    pid_nxt = 8'h5A;
            default: pid_nxt = 8'h1E;
          endcase
        end else if (tx_packet >= 3'd5) begin
          err_nxt = 1'b1;
        end
      end
      SYNC, PID, DATA, CRC_LO, CRC_HI: begin
        if (advance) begin
          if (bit_idx != 3'd7) begin
            bit_idx_nxt = bit_idx + 3'd1;
            shift_nxt   = {1'b0, shift[7:1]};
          end else begin
            bit_idx_nxt = 3'd0;
            case (state)
              SYNC: begin
                state_nxt = PID;
                shift_nxt = pid_q;
              end
              PID, DATA: begin
                if (state == PID)
                  crc_nxt = 16'hFFFF;
                if (state == PID && pid_q != PID_DATA0) begin
                  state_nxt = EOP_SE0;
                end else if (buffer_occupancy != '0) begin
                  state_nxt          = DATA;
                  shift_nxt          = tx_packet_data;
                  get_tx_packet_data = 1'b1;
                end else begin
                  state_nxt = CRC_LO;
                  shift_nxt = ~crc_nxt[7:0];
                end
              end
              CRC_LO: begin
                state_nxt = CRC_HI;
                shift_nxt = ~crc[15:8];
              end
              default: state_nxt = EOP_SE0;
            endcase
          end
        end
      end
      EOP_SE0: begin
        if (bit_end) begin
          if (bit_idx == 3'd1) begin
            state_nxt   = EOP_J;
            bit_idx_nxt = 3'd0;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        if (bit_end)
          state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    case (state)
      IDLE, EOP_J: begin
        dplus_out  = 1'b1;
        dminus_out = 1'b0;
      end
      EOP_SE0: begin
        dplus_out  = 1'b0;
        dminus_out = 1'b0;
      end
      default: begin
        dplus_out  = line_lvl;
        dminus_out = ~line_lvl;
      end
    endcase
  end

  assign tx_transfer_active = (state != IDLE);
  assign tx_error           = err_q;
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: directed and random packets, each checked cycle by
// cycle against an expected line waveform built from a bit-level packet model.
module tb_usb_tx_encoder;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [2:0] tx_packet = 3'd0;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       get_tx_packet_data, dplus_out, dminus_out, tx_transfer_active, tx_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:63];
  int nbytes = 0;
  int base = 0;
  int pop_cnt = 0;
  int pend;

  logic [1:0] exp_lvl [0:1023];
  int exp_bits;
  int pop_cyc [0:63];
  int exp_pops;

  always #5 clk = ~clk;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .dplus_out          (dplus_out),
    .dminus_out         (dminus_out),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error)
  );

  // Buffer model: pops advance the head on the clock edge the strobe is seen.
  always @(posedge clk) if (get_tx_packet_data) pop_cnt <= pop_cnt + 1;
  assign pend             = pop_cnt - base;
  assign buffer_occupancy = (pend < nbytes) ? 7'(nbytes - pend) : 7'd0;
  assign tx_packet_data   = (pend >= 0 && pend < 64) ? mem[pend[5:0]] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc16_ref(input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = mem[i][b] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    return c;
  endfunction

  // Raw field bits -> stuffed wire bits -> NRZI levels, plus per-byte pop cycles.
  task automatic build_model(input logic [2:0] code, input int n);
    bit raw[$];
    int starts[$];
    logic [7:0] sync_b, pid;
    logic [15:0] crc;
    int k, ones, si;
    bit j;
    sync_b = 8'h80;
    pid = (code == 3'd1) ? 8'hC3 : (code == 3'd2) ? 8'hD2 : (code == 3'd3) ? 8'h5A : 8'h1E;
    for (int b = 0; b < 8; b++) raw.push_back(sync_b[b]);
    for (int b = 0; b < 8; b++) raw.push_back(pid[b]);
    if (code == 3'd1) begin
      for (int i = 0; i < n; i++) begin
        starts.push_back(raw.size());
        for (int b = 0; b < 8; b++) raw.push_back(mem[i][b]);
      end
      crc = ~crc16_ref(n);
      for (int b = 0; b < 16; b++) raw.push_back(crc[b]);
    end
    k = 0; ones = 0; si = 0; j = 1'b1;
    for (int r = 0; r < raw.size(); r++) begin
      if (si < starts.size() && starts[si] == r) begin
        pop_cyc[si] = k * CPB - 1;
        si++;
      end
      if (!raw[r]) j = ~j;
      exp_lvl[k] = j ? 2'b10 : 2'b01;
      k++;
      ones = raw[r] ? ones + 1 : 0;
      if (ones == 6) begin
        j = ~j;
        exp_lvl[k] = j ? 2'b10 : 2'b01;
        k++;
        ones = 0;
      end
    end
    exp_lvl[k] = 2'b00; k++;
    exp_lvl[k] = 2'b00; k++;
    exp_lvl[k] = 2'b10; k++;
    exp_bits = k;
    exp_pops = starts.size();
  endtask

  task automatic load_buf(input int n);
    base   = pop_cnt;
    nbytes = n;
  endtask

  // Called just after a falling edge; returns on a falling edge with the encoder idle.
  task automatic send_frame(input logic [2:0] code, input int n, input bit hold);
    int pops0;
    logic exp_get;
    build_model(code, n);
    pops0 = pop_cnt;
    tx_packet = code;
    @(posedge clk);
    #1;
    if (!hold) tx_packet = 3'd0;
    @(negedge clk);
    chk("pre_active", tx_transfer_active, 0);
    chk("pre_line", {dplus_out, dminus_out}, 2'b10);
    for (int c = 0; c < exp_bits * CPB; c++) begin
      @(negedge clk);
      exp_get = 1'b0;
      for (int i = 0; i < exp_pops; i++) if (pop_cyc[i] == c) exp_get = 1'b1;
      chk("line", {dplus_out, dminus_out}, exp_lvl[c / CPB]);
      chk("active", tx_transfer_active, 1);
      chk("get", get_tx_packet_data, exp_get);
      chk("err_in_frame", tx_error, 0);
    end
    @(negedge clk);
    chk("post_active", tx_transfer_active, 0);
    chk("post_line", {dplus_out, dminus_out}, 2'b10);
    chk("pop_count", pop_cnt - pops0, exp_pops);
  endtask

  initial begin
    int hi, pops0, n;
    logic [2:0] code;

    repeat (3) @(negedge clk);
    chk("rst_line", {dplus_out, dminus_out}, 2'b10);
    chk("rst_active", tx_transfer_active, 0);
    chk("rst_get", get_tx_packet_data, 0);
    chk("rst_err", tx_error, 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    load_buf(0);
    send_frame(3'd2, 0, 0);
    send_frame(3'd3, 0, 0);
    send_frame(3'd4, 0, 0);
    send_frame(3'd1, 0, 0);

    mem[0] = 8'hFF;
    load_buf(1);
    send_frame(3'd1, 1, 0);

    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    load_buf(64);
    send_frame(3'd1, 64, 0);

    load_buf(0);
    send_frame(3'd2, 0, 1);
    send_frame(3'd2, 0, 0);

    for (int v = 5; v <= 7; v++) begin
      pops0 = pop_cnt;
      tx_packet = 3'(v);
      @(posedge clk);
      #1;
      tx_packet = 3'd0;
      hi = 0;
      repeat (6) begin
        @(negedge clk);
        if (tx_error) hi++;
        chk("inv_active", tx_transfer_active, 0);
        chk("inv_line", {dplus_out, dminus_out}, 2'b10);
      end
      chk("inv_err_cycles", hi, 1);
      chk("inv_pops", pop_cnt - pops0, 0);
    end

    repeat (10) begin
      code = 3'($urandom_range(1, 4));
      n = (code == 3'd1) ? int'($urandom_range(0, 12)) : 0;
      for (int i = 0; i < n; i++)
        mem[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      load_buf(n);
      send_frame(code, n, 0);
    end

    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    load_buf(64);
    tx_packet = 3'd1;
    @(posedge clk);
    #1;
    tx_packet = 3'd0;
    repeat (300) @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("midrst_dplus", dplus_out, 1);
    chk("midrst_dminus", dminus_out, 0);
    chk("midrst_active", tx_transfer_active, 0);
    chk("midrst_get", get_tx_packet_data, 0);
    pops0 = pop_cnt;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (80) begin
      @(negedge clk);
      chk("after_rst_line", {dplus_out, dminus_out}, 2'b10);
      chk("after_rst_active", tx_transfer_active, 0);
    end
    chk("after_rst_pops", pop_cnt - pops0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
